fact_accel: RTL and testbench

Memory-mapped iterative factorial accelerator that sits on the processor's data-memory bus as a responder alongside GPIO. The CPU writes an operand and a start command with SW, polls status with LW, and reads a 32-bit result. Internally it is a small FSM driving a one-multiply-per-cycle datapath.

---
 rtl/fact_pkg.sv | 34 +++
 rtl/fact_dp.sv | 47 ++++
 rtl/fact_accel.sv | 167 ++++++++++++++++
 tb/tb_fact_accel.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// -----------------------------------------------------------------------------
// fact_pkg
// Shared definitions for the memory-mapped factorial accelerator:
//   - register word offsets (byte address bits [3:2])
//   - FSM state encoding
//   - default operand width and largest n whose factorial fits in 32 bits
//   - helper that packs the STATUS word
// -----------------------------------------------------------------------------
package fact_pkg;

   // Register map, selected by byte address bits [3:2]
   localparam logic [1:0] FACT_N      = 2'd0;
   localparam logic [1:0] FACT_GO     = 2'd1;
   localparam logic [1:0] FACT_STATUS = 2'd2;
   localparam logic [1:0] FACT_RESULT = 2'd3;

   // Default configuration
   localparam int FACT_NW    = 4;
   localparam int FACT_MAX_N = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } fact_state_t;

   // STATUS word layout: {29'b0, err, busy, done}
   function automatic logic [31:0] status_word(input logic err,
                                               input logic busy,
                                               input logic done);
      return {29'b0, err, busy, done};
   endfunction

endpackage

// File: rtl/fact_dp.sv
// -----------------------------------------------------------------------------
// fact_dp
// Iterative factorial datapath: one 32 x NW multiply per cycle.
//
// Ports
//   clk    in   system clock
//   reset  in   asynchronous, active-high; clears cnt and prod
//   load   in   capture cnt <= n, prod <= 1
//   step   in   prod <= prod * cnt (mod 2^32), cnt <= cnt - 1
//   n      in   operand to load [NW-1:0]
//   prod   out  running product
//   last   out  cnt <= 1, the run is complete when sampled in BUSY
// -----------------------------------------------------------------------------
module fact_dp #(
   parameter int NW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          step,
   input  logic [NW-1:0] n,
   output logic [31:0]   prod,
   output logic          last
);

   logic [NW-1:0] cnt;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         prod <= '0;
      end else if (load) begin
         cnt  <= n;
         prod <= 32'd1;
      end else if (step) begin
         // Both operands are 32 bits wide so the product truncates to 32 bits.
         prod <= prod * {{(32-NW){1'b0}}, cnt};
         cnt  <= cnt - NW'(1);
      end
   end

   // n = 0 and n = 1 both finish on the first BUSY cycle with prod = 1.
   assign last = (cnt < NW'(2));

endmodule

// File: rtl/fact_accel.sv
// -----------------------------------------------------------------------------
// fact_accel
// Memory-mapped iterative factorial accelerator (data-memory bus responder).
// Software writes N, writes GO with wd[0]=1, polls STATUS, then reads RESULT.
//
// Register map (a = byte address bits [3:2])
//   0 N       R/W  bits [NW-1:0], upper bits read 0
//   1 GO      WO   wd[0]=1 starts a run (ignored while busy), reads 0
//   2 STATUS  RO   {29'b0, err, busy, done}
//   3 RESULT  RO   last completed factorial (mod 2^32)
//
// Ports
//   clk    in   system clock
//   reset  in   asynchronous, active-high; clears all state
//   we     in   write strobe, already qualified by the address decoder
//   a      in   word select
//   wd     in   write data
//   rd     out  combinational read data for the selected register
//
// Optional feature: define FACT_ERR_EN to reject starts with n > MAX_N. Such a
// start goes straight to DONE with err=1 and RESULT=0. Without it err reads 0
// and every n is computed modulo 2^32.
// -----------------------------------------------------------------------------
module fact_accel
   import fact_pkg::*;
#(
   parameter int NW    = FACT_NW,
   parameter int MAX_N = FACT_MAX_N
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [1:0]  a,
   input  logic [31:0] wd,
   output logic [31:0] rd
);

   fact_state_t   state;
   logic [NW-1:0] n_reg;
   logic [31:0]   result;
   logic          done;
   logic          err;
   logic          busy;

   logic          start;
   logic          n_wr;
   logic          over_max;
   logic          load;
   logic          step;
   logic          last;
   logic [31:0]   prod;

   // ---------------------------------------------------------------- decode
   assign start    = we && (a == FACT_GO) && wd[0];
   assign n_wr     = we && (a == FACT_N);
   assign over_max = (32'(n_reg) > 32'(MAX_N));
   assign busy     = (state == BUSY);

   // Datapath control. A start is only honoured outside BUSY, so a run in
   // progress never sees its cnt/prod reloaded.
   // NOTE: every signal written here gets a default first; without it a path
   // that skips the assignment would infer a latch.
   always_comb begin
      load = 1'b0;
      step = 1'b0;
      if (start && (state != BUSY)) begin
`ifdef FACT_ERR_EN
         load = !over_max;
`else
         load = 1'b1;
`endif
      end
      if ((state == BUSY) && !last) begin
         step = 1'b1;
      end
   end

   fact_dp #(
      .NW (NW)
   ) u_dp (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .step  (step),
      .n     (n_reg),
      .prod  (prod),
      .last  (last)
   );

   // ------------------------------------------------------ FSM + registers
   // NOTE: every control/status register is cleared by reset so software never
   // observes a stale flag or partial result after a mid-run reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         n_reg  <= '0;
         result <= '0;
         done   <= 1'b0;
`ifdef FACT_ERR_EN
         err    <= 1'b0;
`endif
      end else begin
         // N is writable at any time; it only matters at the next start.
         if (n_wr) begin
            n_reg <= wd[NW-1:0];
         end

         case (state)
            IDLE, DONE: begin
               if (start) begin
`ifdef FACT_ERR_EN
                  if (over_max) begin
                     state  <= DONE;
                     done   <= 1'b1;
                     err    <= 1'b1;
                     result <= '0;
                  end else begin
                     state  <= BUSY;
                     done   <= 1'b0;
                     err    <= 1'b0;
                  end
`else
                  state <= BUSY;
                  done  <= 1'b0;
`endif
               end
            end

            BUSY: begin
               // RESULT is only ever updated here, on entry to DONE.
               if (last) begin
                  result <= prod;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

`ifndef FACT_ERR_EN
   assign err = 1'b0;
`endif

   // ------------------------------------------------------------- read mux
   always_comb begin
      rd = '0;
      case (a)
         FACT_N:      rd = {{(32-NW){1'b0}}, n_reg};
         FACT_STATUS: rd = status_word(err, busy, done);
         FACT_RESULT: rd = result;
         default:     rd = '0;
      endcase
   end

   // Bits with no register behind them.
`ifdef FACT_ERR_EN
   logic unused_bits;
   assign unused_bits = ^wd[31:NW];
`else
   logic unused_bits;
   assign unused_bits = ^{wd[31:NW], over_max};
`endif

endmodule

// File: tb/tb_fact_accel.sv
// -----------------------------------------------------------------------------
// tb_fact_accel
// Scoreboard bench for fact_accel. The driver writes N/GO over the register
// bus and pushes the expected outcome (factorial mod 2^32, edge latency, err)
// into a queue. A monitor polls STATUS on falling edges and, when a run
// completes, checks latency, STATUS and RESULT against the queue head.
// -----------------------------------------------------------------------------
module tb_fact_accel;
   import fact_pkg::*;

   localparam int NW = FACT_NW;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [1:0]  a;
   logic [31:0] wd;
   logic [31:0] rd;

   // Bus ownership: the driver owns 'a' while it is writing/reading,
   // otherwise the monitor selects the register it polls.
   logic        drv_active;
   logic [1:0]  drv_a;
   logic [1:0]  mon_a;
   assign a = drv_active ? drv_a : mon_a;

   fact_accel dut (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .a     (a),
      .wd    (wd),
      .rd    (rd)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      int          start_edge;
      int          lat;
      logic [31:0] result;
      logic        err;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: n! reduced modulo 2^32 using wide plain arithmetic.
   function automatic logic [31:0] fact_ref(input int n);
      longint unsigned p;
      p = 1;
      for (int i = 2; i <= n; i++) p = (p * longint'(i)) % 64'h1_0000_0000;
      return p[31:0];
   endfunction

   task automatic write_reg(input logic [1:0] addr, input logic [31:0] data);
      @(posedge clk);
      #1;
      drv_active = 1'b1;
      drv_a      = addr;
      wd         = data;
      we         = 1'b1;
      @(posedge clk);
      #1;
      we         = 1'b0;
      drv_active = 1'b0;
   endtask

   task automatic read_reg(input logic [1:0] addr, output logic [31:0] data);
      @(posedge clk);
      #1;
      drv_active = 1'b1;
      drv_a      = addr;
      #1;
      data       = rd;
      drv_active = 1'b0;
   endtask

   // Accepted start: write N and GO, then record the expected outcome.
   task automatic start_run(input int n);
      exp_t e;
      write_reg(FACT_N, 32'(n));
      write_reg(FACT_GO, 32'd1);
      e.start_edge = edge_cnt;
      e.lat        = (n < 2) ? 1 : n;
      e.result     = fact_ref(n);
      e.err        = 1'b0;
`ifdef FACT_ERR_EN
      if (n > FACT_MAX_N) begin
         e.lat    = 0;
         e.result = 32'd0;
         e.err    = 1'b1;
      end
`endif
      sb.push_back(e);
   endtask

   task automatic wait_idle();
      int budget;
      budget = 0;
      while (sb.size() > 0 && budget < 60) begin
         @(posedge clk);
         budget++;
      end
      if (sb.size() > 0) begin
         check("completion_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   // ------------------------------------------------------------- monitor
   initial begin
      int k;
      mon_a = FACT_STATUS;
      forever begin
         @(negedge clk);
         if (!drv_active && !reset && sb.size() > 0) begin
            mon_a = FACT_STATUS;
            #1;
            k = edge_cnt - sb[0].start_edge;
            if (k < sb[0].lat) begin
               check("status_busy", rd, status_word(1'b0, 1'b1, 1'b0));
            end else begin
               check("status_done", rd, status_word(sb[0].err, 1'b0, 1'b1));
               check("latency", 32'(k), 32'(sb[0].lat));
               mon_a = FACT_RESULT;
               #1;
               check("result", rd, sb[0].result);
               mon_a = FACT_STATUS;
               void'(sb.pop_front());
            end
         end
      end
   end

   // -------------------------------------------------------------- driver
   initial begin
      logic [31:0] data;
      logic        last_err;
      int          n;

      reset      = 1'b1;
      we         = 1'b0;
      wd         = '0;
      drv_active = 1'b0;
      drv_a      = FACT_N;

      // Reset values for every register
      repeat (2) @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         drv_active = 1'b1;
         drv_a      = 2'(i);
         #1;
         check("reset_rd", rd, 32'd0);
      end
      drv_active = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // Directed: 5! = 120, N readback
      start_run(5);
      wait_idle();
      read_reg(FACT_N, data);
      check("n_readback", data, 32'd5);
      read_reg(FACT_GO, data);
      check("go_reads_zero", data, 32'd0);

      // Edge cases: 0! and 1!, then 12! and 13!
      start_run(0);  wait_idle();
      start_run(1);  wait_idle();
      start_run(12); wait_idle();
      start_run(13); wait_idle();

      // Start while busy is ignored; mid-run N write affects only N.
      start_run(6);
      write_reg(FACT_N, 32'd3);
      write_reg(FACT_GO, 32'd1);
      wait_idle();
      read_reg(FACT_N, data);
      check("n_midrun_write", data, 32'd3);

      // Start coinciding with the BUSY->DONE edge is dropped.
      start_run(3);
      @(posedge clk);
      write_reg(FACT_GO, 32'd1);
      wait_idle();
      repeat (3) @(posedge clk);
      read_reg(FACT_STATUS, data);
      check("start_at_done_ignored", data, status_word(1'b0, 1'b0, 1'b1));
      read_reg(FACT_RESULT, data);
      check("result_hold", data, 32'd6);

      // Reset during a run clears everything; a fresh run then works.
      start_run(10);
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      read_reg(FACT_STATUS, data);
      check("midrun_reset_status", data, 32'd0);
      read_reg(FACT_RESULT, data);
      check("midrun_reset_result", data, 32'd0);
      read_reg(FACT_N, data);
      check("midrun_reset_n", data, 32'd0);
      start_run(4);
      wait_idle();

      // Randomised runs, occasionally followed by a GO write with wd[0]=0.
      for (int it = 0; it < 25; it++) begin
         n = int'($urandom_range(0, (1 << NW) - 1));
         start_run(n);
         last_err = sb[sb.size()-1].err;
         wait_idle();
         if ($urandom_range(0, 2) == 0) begin
            write_reg(FACT_GO, $urandom & 32'hFFFF_FFFE);
            repeat (2) @(posedge clk);
            read_reg(FACT_STATUS, data);
            check("go_bit0_clear_ignored", data, status_word(last_err, 1'b0, 1'b1));
            read_reg(FACT_RESULT, data);
            check("go_bit0_clear_result", data, last_err ? 32'd0 : fact_ref(n));
         end
      end

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global bound in case a wait above never returns.
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
